// File: rtl/display_pkg.sv
// Shared types and segment codes for the drink-machine display controller.
// All segment patterns are active-low, bit order gfedcba.
package display_pkg;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    BEBIDA    = 2'd1,
    CANCELADO = 2'd2,
    ERRO      = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_C     = 7'b1000110;

  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

endpackage

// File: rtl/controla_display_if.sv
// Bundle of the display controller's functional signals. The slave side is
// the controller itself; the master side drives the request inputs.
interface controla_display_if;
  logic       View_bebida;
  logic [6:0] seg_bebida;
  logic       sinal_cancel;
  logic       V_sense;
  logic [3:0] credito;
  logic [3:0] digits;
  logic [6:0] segments;
  logic       busy;

  modport master (
    output View_bebida, seg_bebida, sinal_cancel, V_sense, credito,
    input  digits, segments, busy
  );

  modport slave (
    input  View_bebida, seg_bebida, sinal_cancel, V_sense, credito,
    output digits, segments, busy
  );
endinterface

// File: rtl/decod_7seg.sv
// BCD to active-low 7-segment decoder (gfedcba); codes above 9 give blank.
module decod_7seg
  import display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Look up the digit pattern, defaulting to blank for non-BCD codes.
  always_comb begin
    // NOTE: assign a default before any branch so always_comb never infers a latch.
    o_seg = SEG_BLANK;
    if (i_bcd <= 4'd9) o_seg = SEG_DIGIT[i_bcd];
  end

endmodule

// File: rtl/controla_display.sv
// Display controller: holds drink / cancel / error messages for a fixed time,
// shows credit as two decimal digits, and scans the four active-low digits.
module controla_display
  import display_pkg::*;
#(
  parameter int SCAN_DIV    = 50_000,
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic               clock,
  input  logic               reset_n,
  controla_display_if.slave  bus
);

  localparam int SCAN_W = (SCAN_DIV    > 2) ? $clog2(SCAN_DIV)    : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;

  state_t             r_state;
  state_t             w_next_state;
  logic [HOLD_W-1:0]  r_hold;
  logic [HOLD_W-1:0]  w_hold_next;
  logic               w_hold_done;
  logic               w_load_latch;
  logic [6:0]         r_latch;
  logic               r_busy;

  logic [SCAN_W-1:0]  r_presc;
  logic [1:0]         r_idx;

  logic [3:0]         w_units;
  logic               w_tens_on;
  logic [3:0]         w_bcd;
  logic [6:0]         w_dec;
  logic [6:0]         w_seg_next;
  logic [3:0]         r_digits;
  logic [6:0]         r_segments;

  assign w_hold_done = (r_hold == HOLD_W'(HOLD_CYCLES - 1));

  // State register: message state, hold timer, drink latch and busy flag.
  always_ff @(posedge clock) begin
    // NOTE: every control register has a synchronous reset; there is no memory array here to leave unreset.
    if (!reset_n) begin
      // NOTE: non-blocking assignments keep all flops updating from the same pre-edge values.
      r_state <= OCIOSO;
      r_hold  <= '0;
      r_latch <= SEG_BLANK;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_hold  <= w_hold_next;
      if (w_load_latch) r_latch <= bus.seg_bebida;
      r_busy  <= (w_next_state != OCIOSO);
    end
  end

  // Next-state logic: fault beats cancel beats drink; held messages time out.
  always_comb begin
    w_next_state = r_state;
    w_hold_next  = r_hold + 1'b1;
    w_load_latch = 1'b0;
    unique case (r_state)
      OCIOSO: begin
        w_hold_next = '0;
        if (bus.V_sense)           w_next_state = ERRO;
        else if (bus.sinal_cancel) w_next_state = CANCELADO;
        else if (bus.View_bebida) begin
          w_next_state = BEBIDA;
          w_load_latch = 1'b1;
        end
      end
      BEBIDA, CANCELADO: begin
        if (bus.V_sense)  w_next_state = ERRO;
        else if (w_hold_done) w_next_state = OCIOSO;
      end
      ERRO: begin
        if (bus.V_sense)      w_hold_next  = '0;
        else if (w_hold_done) w_next_state = OCIOSO;
      end
      default: w_next_state = OCIOSO;
    endcase
    // Any state change starts the hold timer from zero.
    if (w_next_state != r_state) w_hold_next = '0;
  end

  // Scan timing: prescaler sets dwell time, index walks the four digits.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
    end else if (r_presc == SCAN_W'(SCAN_DIV - 1)) begin
      r_presc <= '0;
      r_idx   <= r_idx + 2'd1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Credit is at most 15, so a single conditional subtract yields the units digit.
  assign w_tens_on = (bus.credito >= 4'd10);
  assign w_units   = w_tens_on ? (bus.credito - 4'd10) : bus.credito;
  assign w_bcd     = (r_idx == 2'd2) ? 4'd1 : w_units;

  decod_7seg u_decod (
    .i_bcd (w_bcd),
    .o_seg (w_dec)
  );

  // Output logic: choose the pattern for the digit currently being scanned.
  always_comb begin
    w_seg_next = SEG_BLANK;
    unique case (r_idx)
      2'd0: if (r_state == BEBIDA) w_seg_next = r_latch;
      2'd1: w_seg_next = (r_state == ERRO) ? SEG_DASH : w_dec;
      2'd2: begin
        if (r_state == ERRO) w_seg_next = SEG_DASH;
        else if (w_tens_on)  w_seg_next = w_dec;
      end
      2'd3: begin
        if (r_state == ERRO)           w_seg_next = SEG_E;
        else if (r_state == CANCELADO) w_seg_next = SEG_C;
      end
      default: w_seg_next = SEG_BLANK;
    endcase
  end

  // Enables and segments change on the same edge so no digit shows a neighbour's pattern.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_digits   <= 4'b1111;
      r_segments <= SEG_BLANK;
    end else begin
      r_digits   <= ~(4'b0001 << r_idx);
      r_segments <= w_seg_next;
    end
  end

  assign bus.digits   = r_digits;
  assign bus.segments = r_segments;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_controla_display.sv
// Bench for controla_display: directed scenarios plus a random phase, every
// cycle compared against a message-level reference model.
module tb_controla_display;

  localparam int SCAN_DIV = 4;
  localparam int HOLD     = 20;

  localparam int M_IDLE  = 0;
  localparam int M_DRINK = 1;
  localparam int M_CANCEL = 2;
  localparam int M_ERROR = 3;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  controla_display_if bus ();

  controla_display #(
    .SCAN_DIV    (SCAN_DIV),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which message is up, cycles it has left, latched drink, cycles since reset.
  int         m_mode = M_IDLE;
  int         m_left = 0;
  logic [6:0] m_latch = 7'h7F;
  int         m_cyc  = 0;

  logic [6:0] dig_tab [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pattern the display should show at scan position pos given the model state.
  function automatic logic [6:0] exp_seg(input int pos);
    int cr;
    cr = int'(bus.credito);
    case (pos)
      0: return (m_mode == M_DRINK) ? m_latch : 7'b1111111;
      1: return (m_mode == M_ERROR) ? 7'b0111111 : dig_tab[cr % 10];
      2: begin
        if (m_mode == M_ERROR) return 7'b0111111;
        if (cr >= 10)          return dig_tab[cr / 10];
        return 7'b1111111;
      end
      default: begin
        if (m_mode == M_ERROR)  return 7'b0000110;
        if (m_mode == M_CANCEL) return 7'b1000110;
        return 7'b1111111;
      end
    endcase
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then compare outputs.
  task automatic tick();
    logic [3:0] e_dig;
    logic [6:0] e_seg;
    logic       e_busy;
    int         pos;
    @(posedge clock);
    if (!reset_n) begin
      e_dig   = 4'b1111;
      e_seg   = 7'b1111111;
      m_mode  = M_IDLE;
      m_left  = 0;
      m_latch = 7'h7F;
      m_cyc   = 0;
    end else begin
      pos   = (m_cyc / SCAN_DIV) % 4;
      e_dig = ~(4'b0001 << pos);
      e_seg = exp_seg(pos);
      m_cyc++;
      if (bus.V_sense) begin
        m_mode = M_ERROR;
        m_left = HOLD;
      end else if (m_mode == M_IDLE) begin
        if (bus.sinal_cancel) begin
          m_mode = M_CANCEL;
          m_left = HOLD;
        end else if (bus.View_bebida) begin
          m_mode  = M_DRINK;
          m_left  = HOLD;
          m_latch = bus.seg_bebida;
        end
      end else begin
        m_left--;
        if (m_left == 0) m_mode = M_IDLE;
      end
    end
    e_busy = (m_mode != M_IDLE);
    #1;
    check("digits",   32'(bus.digits),   32'(e_dig));
    check("segments", 32'(bus.segments), 32'(e_seg));
    check("busy",     32'(bus.busy),     32'(e_busy));
  endtask

  // Ticks until busy falls (bounded); returns how many ticks that took.
  task automatic run_until_idle(output int cnt);
    cnt = 0;
    for (int i = 0; i < 4 * HOLD; i++) begin
      tick();
      cnt++;
      if (!bus.busy) break;
    end
  endtask

  initial begin
    int cnt;
    bus.View_bebida  = 1'b0;
    bus.seg_bebida   = 7'h7F;
    bus.sinal_cancel = 1'b0;
    bus.V_sense      = 1'b0;
    bus.credito      = 4'd0;

    // Reset held for three cycles.
    reset_n = 1'b0;
    repeat (3) tick();
    check("reset_digits", 32'(bus.digits), 32'h0000_000F);
    reset_n = 1'b1;
    tick();
    check("scan_start", 32'(bus.digits), 32'b1110);

    // Idle credit display, two digits and one digit.
    bus.credito = 4'd12;
    repeat (20) tick();
    bus.credito = 4'd5;
    repeat (20) tick();

    // Drink pulse, second pulse mid-hold must not extend the message.
    bus.seg_bebida  = 7'b0011001;
    bus.View_bebida = 1'b1;
    tick();
    bus.View_bebida = 1'b0;
    check("drink_busy", 32'(bus.busy), 32'd1);
    repeat (7) tick();
    bus.seg_bebida  = 7'b1111000;
    bus.View_bebida = 1'b1;
    tick();
    bus.View_bebida = 1'b0;
    run_until_idle(cnt);
    check("drink_hold_len", 32'(cnt), 32'(HOLD - 8));

    // Cancel with a simultaneous drink request.
    bus.credito      = 4'd15;
    bus.sinal_cancel = 1'b1;
    bus.View_bebida  = 1'b1;
    bus.seg_bebida   = 7'b0000000;
    tick();
    bus.sinal_cancel = 1'b0;
    bus.View_bebida  = 1'b0;
    run_until_idle(cnt);
    check("cancel_hold_len", 32'(cnt), 32'(HOLD));

    // Fault during a drink hold; error persists HOLD cycles after release.
    bus.seg_bebida  = 7'b0010010;
    bus.View_bebida = 1'b1;
    tick();
    bus.View_bebida = 1'b0;
    repeat (3) tick();
    bus.V_sense = 1'b1;
    repeat (10) tick();
    bus.V_sense = 1'b0;
    run_until_idle(cnt);
    check("error_hold_len", 32'(cnt), 32'(HOLD));

    // Fault and drink together from idle: error wins.
    bus.V_sense     = 1'b1;
    bus.View_bebida = 1'b1;
    tick();
    bus.V_sense     = 1'b0;
    bus.View_bebida = 1'b0;
    run_until_idle(cnt);

    // Reset in the middle of a drink hold.
    bus.View_bebida = 1'b1;
    tick();
    bus.View_bebida = 1'b0;
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    check("midreset_busy", 32'(bus.busy), 32'd0);
    reset_n = 1'b1;
    repeat (4) tick();

    // Random phase.
    for (int i = 0; i < 800; i++) begin
      bus.View_bebida  = ($urandom % 8) == 0;
      bus.sinal_cancel = ($urandom % 30) == 0;
      bus.seg_bebida   = 7'($urandom);
      if (($urandom % 40) == 0) bus.V_sense = ~bus.V_sense;
      if (($urandom % 10) == 0) bus.credito = 4'($urandom);
      reset_n = ($urandom % 250) != 0;
      tick();
    end
    bus.V_sense = 1'b0;
    reset_n     = 1'b1;
    repeat (2 * HOLD) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
